// File: rtl/output_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// output_port_arbiter_pkg
//   Shared definitions for the wormhole output-port allocator of the 5-port
//   mesh router: arbitration FSM states, requester port indices and helpers
//   that locate the flit control bits and size the credit counter.
// -----------------------------------------------------------------------------
package output_port_arbiter_pkg;

    // Allocator states: free for arbitration, or held by one packet.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Requester indices into req / flit_in / read_en / grant.
    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;

    // TAIL sits in the flit MSB, HEAD just below it.
    function automatic int flit_tail_pos(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int flit_head_pos(input int data_width);
        return data_width - 2;
    endfunction

    // Counter wide enough to hold 0..depth inclusive.
    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// output_port_arbiter_if
//   Bundles the requester side (req / flit_in / read_en), the output link
//   (flit_out / flit_valid / credit_in) and the status outputs (grant /
//   credits / err) of one output-port allocator.
//   master : the surrounding router (input buffers + downstream link)
//   slave  : the allocator itself
// -----------------------------------------------------------------------------
interface output_port_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CREDIT_DEPTH = 4
);
    localparam int CRED_W = $clog2(CREDIT_DEPTH + 1);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] flit_in;
    logic [NUM_REQ-1:0]            read_en;
    logic [DATA_WIDTH-1:0]         flit_out;
    logic                          flit_valid;
    logic                          credit_in;
    logic [NUM_REQ-1:0]            grant;
    logic [CRED_W-1:0]             credits;
    logic [1:0]                    err;

    modport master (
        output req, flit_in, credit_in,
        input  read_en, flit_out, flit_valid, grant, credits, err
    );

    modport slave (
        input  req, flit_in, credit_in,
        output read_en, flit_out, flit_valid, grant, credits, err
    );

endinterface

// File: rtl/output_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter_rr_arbiter
//   Combinational round-robin pick. Searches req starting at ptr+1 and wrapping,
//   returning the first set request as a one-hot grant plus its index.
//   The pointer itself is owned by the caller, which advances it only when a
//   packet completes.
// Ports
//   req  in  NUM_REQ  request vector
//   ptr  in  PTR_W    index of the most recent winner
//   gnt  out NUM_REQ  one-hot winner (0 when no request)
//   idx  out PTR_W    winner index (0 when no request)
//   any  out 1        at least one request present
// -----------------------------------------------------------------------------
module output_port_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        logic [PTR_W-1:0] cidx;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cidx = '0;
        // Offsets 1..NUM_REQ: the last winner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cidx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cidx]) begin
                any       = 1'b1;
                gnt[cidx] = 1'b1;
                idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter
//   Wormhole output-port allocator. Shares one output link between the N/S/E/W
//   first-word-fall-through VC buffers. Arbitrates round-robin on packet heads,
//   holds the grant from head to tail, pops flits with read_en and tracks the
//   downstream buffer space with a credit counter.
// Ports
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    slave modport of output_port_arbiter_if:
//          req/flit_in/credit_in in; read_en (combinational, one-hot),
//          flit_out/flit_valid (registered, 1-cycle latency), grant, credits,
//          err (sticky: [0] credit overflow, [1] non-head flit seen in IDLE) out
// -----------------------------------------------------------------------------
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output_port_arbiter_if.slave  bus
);

    localparam int CRED_W   = cred_width(CREDIT_DEPTH);
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAIL_POS = flit_tail_pos(DATA_WIDTH);
    localparam int HEAD_POS = flit_head_pos(DATA_WIDTH);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDIT_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(NUM_REQ - 1);

    state_t                state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      owner;
    logic [NUM_REQ-1:0]    grant_q;
    logic [CRED_W-1:0]     credits_q;
    logic [1:0]            err_q;
    logic [DATA_WIDTH-1:0] flit_p1;
    logic                  vld_p1;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_any;

    logic [PTR_W-1:0]      sel_idx;
    logic                  sel_ok;
    logic [DATA_WIDTH-1:0] sel_flit;
    logic                  sel_head;
    logic                  sel_tail;
    logic                  send;
    logic [NUM_REQ-1:0]    read_en_c;

    output_port_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req (bus.req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // ---- stage p0: select requester, decide pop (combinational) ----
    always_comb begin
        sel_idx = arb_idx;
        sel_ok  = arb_any;
        if (state == ST_LOCKED) begin
            // Only the packet owner may move; everyone else waits for its tail.
            sel_idx = owner;
            sel_ok  = bus.req[owner];
        end

        sel_flit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == sel_idx) begin
                sel_flit = bus.flit_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sel_head = sel_flit[HEAD_POS];
        sel_tail = sel_flit[TAIL_POS];

        // Discarded stray flits also consume a credit slot: every pop counts.
        send = sel_ok && (credits_q != '0) && !reset;

        read_en_c = '0;
        if (send) begin
            read_en_c = (state == ST_LOCKED) ? grant_q : arb_gnt;
        end
    end

    // ---- stage p1: FSM, pointers, credit counter, output flit register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= PTR_RST;
            owner     <= '0;
            grant_q   <= '0;
            credits_q <= CRED_MAX;
            err_q     <= '0;
            flit_p1   <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;

            if (send) begin
                unique case (state)
                    ST_IDLE: begin
                        if (sel_head) begin
                            flit_p1 <= sel_flit;
                            vld_p1  <= 1'b1;
                            if (sel_tail) begin
                                rr_ptr <= sel_idx;
                            end else begin
                                state   <= ST_LOCKED;
                                owner   <= sel_idx;
                                grant_q <= arb_gnt;
                            end
                        end else begin
                            // Orphan body/tail flit: drop it so the buffer drains.
                            err_q[1] <= 1'b1;
                            rr_ptr   <= sel_idx;
                        end
                    end
                    ST_LOCKED: begin
                        flit_p1 <= sel_flit;
                        vld_p1  <= 1'b1;
                        if (sel_tail) begin
                            state   <= ST_IDLE;
                            grant_q <= '0;
                            rr_ptr  <= owner;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (send && !bus.credit_in) begin
                credits_q <= credits_q - CRED_W'(1);
            end else if (!send && bus.credit_in) begin
                if (credits_q == CRED_MAX) begin
                    err_q[0] <= 1'b1;
                end else begin
                    credits_q <= credits_q + CRED_W'(1);
                end
            end
        end
    end

    assign bus.read_en    = read_en_c;
    assign bus.flit_out   = flit_p1;
    assign bus.flit_valid = vld_p1;
    assign bus.grant      = grant_q;
    assign bus.credits    = credits_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;
    import output_port_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int CD = 4;
    localparam logic [DW-1:0] HB = 32'h4000_0000;
    localparam logic [DW-1:0] TB = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    output_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CREDIT_DEPTH(CD)) bus ();

    output_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CREDIT_DEPTH(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Upstream FWFT buffers and per-requester request suppression.
    logic [DW-1:0] q[NR][$];
    bit            hold[NR];

    // Behavioural model: owner (-1 = free), last winner, credit count, sticky errors,
    // last forwarded flit.
    int            m_owner;
    int            m_last;
    int            m_credits;
    logic [1:0]    m_err;
    logic [DW-1:0] m_fout;
    logic          m_fvld;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = NR - 1;
        m_credits = CD;
        m_err     = '0;
        m_fout    = '0;
        m_fvld    = 1'b0;
        for (int i = 0; i < NR; i++) begin
            q[i].delete();
            hold[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive at the falling edge, compare everything against the
    // model, then advance the model across the coming rising edge.
    task automatic step(input bit cin);
        logic [NR-1:0]    r;
        logic [NR*DW-1:0] fv;
        logic [NR-1:0]    exp_rd;
        logic [NR-1:0]    exp_gnt;
        logic [DW-1:0]    f;
        int               w;
        int               c;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            r[i] = (q[i].size() > 0) && !hold[i];
            fv[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : DW'($urandom);
        end
        bus.req       = r;
        bus.flit_in   = fv;
        bus.credit_in = cin;
        #1;
        w = -1;
        if (m_credits > 0) begin
            if (m_owner >= 0) begin
                if (r[m_owner]) w = m_owner;
            end else begin
                for (int k = 1; k <= NR; k++) begin
                    c = (m_last + k) % NR;
                    if (w < 0 && r[c]) w = c;
                end
            end
        end
        exp_rd  = (w >= 0) ? (NR'(1) << w) : '0;
        exp_gnt = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
        check("read_en",    64'(bus.read_en),    64'(exp_rd));
        check("grant",      64'(bus.grant),      64'(exp_gnt));
        check("credits",    64'(bus.credits),    64'(m_credits));
        check("err",        64'(bus.err),        64'(m_err));
        check("flit_valid", 64'(bus.flit_valid), 64'(m_fvld));
        check("flit_out",   64'(bus.flit_out),   64'(m_fout));

        m_fvld = 1'b0;
        if (w >= 0) begin
            f = q[w].pop_front();
            if (m_owner >= 0) begin
                m_fout = f;
                m_fvld = 1'b1;
                if (f[DW-1]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (f[DW-2]) begin
                m_fout = f;
                m_fvld = 1'b1;
                if (f[DW-1]) m_last = w;
                else         m_owner = w;
            end else begin
                m_err[1] = 1'b1;
                m_last   = w;
            end
        end
        if (w >= 0 && !cin) begin
            m_credits--;
        end else if (w < 0 && cin) begin
            if (m_credits == CD) m_err[0] = 1'b1;
            else                 m_credits++;
        end
    endtask

    // Reset asserted between edges while traffic may be present.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_read_en",    64'(bus.read_en),    64'(0));
        check("rst_grant",      64'(bus.grant),      64'(0));
        check("rst_credits",    64'(bus.credits),    64'(CD));
        check("rst_flit_valid", 64'(bus.flit_valid), 64'(0));
        check("rst_flit_out",   64'(bus.flit_out),   64'(0));
        check("rst_err",        64'(bus.err),        64'(0));
        bus.req       = '0;
        bus.credit_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic push_pkt(input int i);
        int            len;
        logic [DW-1:0] f;
        if ($urandom_range(0, 15) == 0) begin
            q[i].push_back({2'b00, 30'($urandom)});
            return;
        end
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
            f = {2'b00, 30'($urandom)};
            if (j == 0) f[DW-2] = 1'b1;
            else if ($urandom_range(0, 7) == 0) f[DW-2] = 1'b1;
            if (j == len - 1) f[DW-1] = 1'b1;
            q[i].push_back(f);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cp;
        reset         = 1'b1;
        bus.req       = '0;
        bus.flit_in   = '0;
        bus.credit_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Post-reset idle state
        step(1'b0);
        check("init_credits", 64'(bus.credits), 64'(4));
        check("init_grant",   64'(bus.grant),   64'(0));

        // Single-flit packets from all four: N,S,E,W,N,... one per cycle
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 3; j++)
                q[i].push_back(HB | TB | DW'(i << 8) | DW'(j));
        for (int s = 0; s < 8; s++) begin
            step(1'b1);
            check("rr_read_en", 64'(bus.read_en), 64'(NR'(1) << (s % NR)));
            if (s > 0) check("rr_flit_valid", 64'(bus.flit_valid), 64'(1));
        end

        // Reset in the middle of that stream
        do_reset();

        // Wormhole lock: N sends H,B,T while E waits
        q[PORT_N].push_back(HB | 32'h1);
        q[PORT_N].push_back(32'h2);
        q[PORT_N].push_back(TB | 32'h3);
        q[PORT_E].push_back(HB | TB | 32'h4);
        step(1'b1); check("wh_rd0", 64'(bus.read_en), 64'(4'b0001));
        step(1'b1); check("wh_rd1", 64'(bus.read_en), 64'(4'b0001));
                    check("wh_gnt1", 64'(bus.grant), 64'(4'b0001));
                    check("wh_head_out", 64'(bus.flit_out), 64'(HB | 32'h1));
        step(1'b1); check("wh_rd2", 64'(bus.read_en), 64'(4'b0001));
                    check("wh_gnt2", 64'(bus.grant), 64'(4'b0001));
        step(1'b1); check("wh_rd3", 64'(bus.read_en), 64'(4'b0100));
                    check("wh_gnt3", 64'(bus.grant), 64'(4'b0000));
        step(1'b1); check("wh_e_out", 64'(bus.flit_out), 64'(HB | TB | 32'h4));

        // Credit stall: 6-flit packet, no returns
        do_reset();
        q[PORT_N].push_back(HB | 32'h10);
        for (int j = 1; j < 5; j++) q[PORT_N].push_back(DW'(32'h10 + j));
        q[PORT_N].push_back(TB | 32'h15);
        for (int s = 0; s < 4; s++) begin
            step(1'b0);
            check("cs_send", 64'(bus.read_en), 64'(4'b0001));
        end
        step(1'b0); check("cs_stall0", 64'(bus.read_en), 64'(0));
                    check("cs_zero",   64'(bus.credits), 64'(0));
        step(1'b0); check("cs_stall1", 64'(bus.read_en), 64'(0));
        step(1'b1); check("cs_stall2", 64'(bus.read_en), 64'(0));
        step(1'b0); check("cs_one",    64'(bus.read_en), 64'(4'b0001));
        step(1'b0); check("cs_stall3", 64'(bus.read_en), 64'(0));

        // Simultaneous send and return; overflow at full
        hold[PORT_N] = 1'b1;
        step(1'b1);
        step(1'b1);
        hold[PORT_N] = 1'b0;
        step(1'b1); check("cr_both_rd", 64'(bus.read_en), 64'(4'b0001));
                    check("cr_two",     64'(bus.credits), 64'(2));
        step(1'b1); check("cr_still2",  64'(bus.credits), 64'(2));
        step(1'b1); check("cr_three",   64'(bus.credits), 64'(3));
        step(1'b1); check("cr_four",    64'(bus.credits), 64'(4));
                    check("cr_noerr",   64'(bus.err),     64'(0));
        step(1'b0); check("cr_sat",     64'(bus.credits), 64'(4));
                    check("cr_ovf",     64'(bus.err),     64'(2'b01));

        // Orphan body flit at S, then a bubble inside N's packet
        do_reset();
        q[PORT_S].push_back(32'h0000_0055);
        step(1'b1); check("pe_pop",  64'(bus.read_en),    64'(4'b0010));
        step(1'b1); check("pe_vld",  64'(bus.flit_valid), 64'(0));
                    check("pe_err",  64'(bus.err),        64'(2'b10));
        q[PORT_N].push_back(HB | 32'h20);
        q[PORT_N].push_back(32'h21);
        q[PORT_N].push_back(32'h22);
        q[PORT_N].push_back(TB | 32'h23);
        step(1'b1); check("bb_head", 64'(bus.read_en), 64'(4'b0001));
        hold[PORT_N] = 1'b1;
        q[PORT_E].push_back(HB | TB | 32'h24);
        step(1'b1); check("bb_rd0",  64'(bus.read_en), 64'(0));
                    check("bb_gnt0", 64'(bus.grant),   64'(4'b0001));
        step(1'b1); check("bb_rd1",  64'(bus.read_en), 64'(0));
                    check("bb_gnt1", 64'(bus.grant),   64'(4'b0001));
        hold[PORT_N] = 1'b0;
        step(1'b1); check("bb_b1", 64'(bus.read_en), 64'(4'b0001));
        step(1'b1); check("bb_b2", 64'(bus.read_en), 64'(4'b0001));
        step(1'b1); check("bb_t",  64'(bus.read_en), 64'(4'b0001));
        step(1'b1); check("bb_e",  64'(bus.read_en), 64'(4'b0100));

        // Randomised traffic with varying credit return rates
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0 && cyc % 1000 == 0) do_reset();
            for (int i = 0; i < NR; i++) begin
                if (q[i].size() < 2 && $urandom_range(0, 3) == 0) push_pkt(i);
                hold[i] = ($urandom_range(0, 4) == 0);
            end
            case ((cyc / 300) % 3)
                0:       cp = 10;
                1:       cp = 50;
                default: cp = 90;
            endcase
            step($urandom_range(0, 99) < cp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
